// File: rtl/pps_gen.sv
// -----------------------------------------------------------------------------
// pps_gen
// Transmit side of the 1PPS interface. Regenerates the board PPS output pulse
// from the TSC second strobe with a programmable phase offset, width and
// polarity. The block keeps emitting pulses from its own phase counter
// (holdover) when the strobe goes missing, and flags strobes that arrive off
// phase.
//
// Ports
//   clk          : system clock, all logic on posedge
//   rst_n        : asynchronous active-low reset
//   tsc_1pps     : 1-cycle strobe marking TSC phase 0
//   cfg_enable   : level; 0 forces IDLE with the output inactive
//   cfg_offset   : pulse start phase, cycles after tsc_1pps
//   cfg_width    : pulse width in cycles, 0 = no pulse
//   cfg_polarity : 1 = active-high pulse, 0 = active-low
//   cfg_load     : 1-cycle strobe capturing cfg_offset/width/polarity
//   cfg_pending  : shadow captured but not yet applied
//   pps_out      : registered PPS output pin
//   pps_active   : 1 while the pulse is asserted (polarity independent)
//   pps_count    : pulses emitted since reset, wraps
//   holdover     : last second boundary was internal (free-wheel)
//   sync_err     : 1-cycle strobe, tsc_1pps arrived off phase
//   dbg_state    : current FSM state (IDLE=0, SYNC=1, ARMED=2, PULSE=3)
//
// Interface timing: cfg_load and tsc_1pps are single-cycle strobes sampled on
// the posedge with no back-pressure; every output is registered and changes
// only on a posedge or on reset assertion.
// -----------------------------------------------------------------------------
module pps_gen #(
  parameter int unsigned CLKS_PER_SEC = 200000000,
  parameter int unsigned CW           = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tsc_1pps,
  input  logic          cfg_enable,
  input  logic [CW-1:0] cfg_offset,
  input  logic [CW-1:0] cfg_width,
  input  logic          cfg_polarity,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          pps_out,
  output logic          pps_active,
  output logic [31:0]   pps_count,
  output logic          holdover,
  output logic          sync_err,
  output logic [1:0]    dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;
  localparam logic [1:0] S_PULSE = 2'd3;

  localparam logic [CW-1:0] PH_LAST = CW'(CLKS_PER_SEC - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_ph;
  logic [CW-1:0] r_sh_offset;
  logic [CW-1:0] r_sh_width;
  logic          r_sh_pol;
  logic          r_pending;
  logic [CW-1:0] r_offset;
  logic [CW-1:0] r_width;
  logic          r_pol;
  logic [CW-1:0] r_wcnt;
  logic          r_active;
  logic          r_pps_out;
  logic [31:0]   r_count;
  logic          r_holdover;
  logic          r_sync_err;

  logic [CW-1:0] w_p;
  logic          w_boundary;
  logic          w_free_tick;
  logic          w_tracking;
  logic          w_copy;
  logic [CW-1:0] w_sh_width_clamped;
  logic [CW-1:0] w_offset;
  logic [CW-1:0] w_width;
  logic          w_pol;
  logic          w_match;
  logic [CW-1:0] w_ph_nxt;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_wcnt_nxt;
  logic          w_active_nxt;
  logic          w_count_inc;
  logic          w_holdover_nxt;
  logic          w_sync_err_nxt;

  // Effective phase: the strobe itself is phase 0 regardless of the counter.
  assign w_p         = tsc_1pps ? '0 : r_ph;
  assign w_boundary  = (w_p == '0);
  // The counter wrapped to 0 on its own: a free-wheel second boundary.
  assign w_free_tick = (r_ph == '0) && !tsc_1pps;
  assign w_tracking  = (r_state == S_ARMED) || (r_state == S_PULSE);

  assign w_ph_nxt = tsc_1pps ? CW'(1) :
                    (r_ph == PH_LAST) ? '0 : r_ph + CW'(1);

  // While not generating pulses the shadow can be applied at once; otherwise
  // it waits for a second boundary so a second never mixes two configs.
  assign w_copy = r_pending &&
                  ((r_state == S_IDLE) || (r_state == S_SYNC) || w_boundary);

  // A width of a full second or more would never let the pulse end before
  // the next start, so it is limited to one cycle short of a second.
  assign w_sh_width_clamped = (r_sh_width > PH_LAST) ? PH_LAST : r_sh_width;

  // Config seen by this cycle's decisions, including a same-cycle copy, so an
  // offset of 0 fires on the boundary with the newly applied values.
  assign w_offset = w_copy ? r_sh_offset        : r_offset;
  assign w_width  = w_copy ? w_sh_width_clamped : r_width;
  assign w_pol    = w_copy ? r_sh_pol           : r_pol;

  assign w_match = (r_state == S_ARMED) && (w_p == w_offset) && (w_width != '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_active_nxt = r_active;
    w_count_inc  = 1'b0;
    if (!cfg_enable) begin
      w_state_nxt  = S_IDLE;
      w_active_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_SYNC;
          w_active_nxt = 1'b0;
        end
        S_SYNC: begin
          w_active_nxt = 1'b0;
          if (tsc_1pps) begin
            w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_match) begin
            w_state_nxt  = S_PULSE;
            w_wcnt_nxt   = w_width;
            w_active_nxt = 1'b1;
            w_count_inc  = 1'b1;
          end
        end
        S_PULSE: begin
          // A start match here is ignored; the pulse always runs to its end.
          if (r_wcnt == CW'(1)) begin
            w_state_nxt  = S_ARMED;
            w_wcnt_nxt   = '0;
            w_active_nxt = 1'b0;
          end else begin
            w_wcnt_nxt = r_wcnt - CW'(1);
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_active_nxt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_holdover_nxt = 1'b0;
    w_sync_err_nxt = 1'b0;
    if (cfg_enable && w_tracking) begin
      if (tsc_1pps) begin
        w_holdover_nxt = 1'b0;
      end else if (w_free_tick) begin
        w_holdover_nxt = 1'b1;
      end else begin
        w_holdover_nxt = r_holdover;
      end
      // An on-time strobe lands on the cycle the counter has just wrapped
      // from CLKS_PER_SEC-1 to 0. In holdover the strobe is re-acquired
      // silently.
      w_sync_err_nxt = tsc_1pps && (r_ph != '0) && !r_holdover;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_sh_offset <= '0;
      r_sh_width  <= '0;
      r_sh_pol    <= 1'b0;
      r_pending   <= 1'b0;
      r_offset    <= '0;
      r_width     <= '0;
      r_pol       <= 1'b1;
      r_wcnt      <= '0;
      r_active    <= 1'b0;
      r_pps_out   <= 1'b0;
      r_count     <= '0;
      r_holdover  <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_active   <= w_active_nxt;
      r_pps_out  <= w_active_nxt ? w_pol : ~w_pol;
      r_holdover <= w_holdover_nxt;
      r_sync_err <= w_sync_err_nxt;
      if (w_count_inc) begin
        r_count <= r_count + 32'd1;
      end
      if (w_copy) begin
        r_offset <= r_sh_offset;
        r_width  <= w_sh_width_clamped;
        r_pol    <= r_sh_pol;
      end
      // A load on the copy cycle wins: the new shadow stays pending.
      if (cfg_load) begin
        r_sh_offset <= cfg_offset;
        r_sh_width  <= cfg_width;
        r_sh_pol    <= cfg_polarity;
        r_pending   <= 1'b1;
      end else if (w_copy) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign cfg_pending = r_pending;
  assign pps_out     = r_pps_out;
  assign pps_active  = r_active;
  assign pps_count   = r_count;
  assign holdover    = r_holdover;
  assign sync_err    = r_sync_err;
  assign dbg_state   = r_state;

endmodule
